// File: rtl/onewire_cmd_ctrl.sv
// onewire_cmd_ctrl: queues host requests, frames them with a Maxim CRC-8, drives the onewire master and
// returns one checked response per request, retrying on receive error, timeout or bad CRC.
module onewire_cmd_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRY      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [7:0]                    i_cmd_addr,
    input  logic [7:0]                    i_cmd_op,
    input  logic [31:0]                   i_cmd_payload,
    output logic [55:0]                   o_tx_data,
    output logic                          o_tx_start,
    input  logic [55:0]                   i_rx_command,
    input  logic                          i_rx_error,
    input  logic                          i_rx_done,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [55:0]                   o_rsp_data,
    output logic [1:0]                    o_rsp_status,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    typedef enum logic [2:0] {IDLE, TXCRC, SEND, WAIT, RXCRC, RESP} state_t;
    state_t        state_q, state_d;
    logic [47:0]   mem_q [FIFO_DEPTH];
    logic [47:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic [47:0]   body_q, body_d, crc_src;
    logic [55:0]   tx_q, tx_d, rx_q, rx_d;
    logic [7:0]    crc_q, crc_d, crc_nxt;
    logic [5:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [1:0]    status_q, status_d;
    logic          push, pop, fail;
    assign o_cmd_ready  = level_q != LW'(FIFO_DEPTH);
    assign push         = i_cmd_valid && o_cmd_ready;
    assign pop          = state_q == IDLE && level_q != '0;
    // One serial CRC engine shared by the transmit body and the received frame body
    assign crc_src      = state_q == TXCRC ? body_q : rx_q[55:8];
    assign crc_nxt      = {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ crc_src[cnt_q]) ? 8'h8C : 8'h00);
    assign o_tx_data    = tx_q;
    assign o_tx_start   = state_q == SEND;
    assign o_rsp_valid  = state_q == RESP;
    assign o_rsp_data   = rx_q;
    assign o_rsp_status = status_q;
    assign o_busy       = state_q != IDLE;
    assign o_fifo_level = level_q;
    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_d     = push ? wr_q + 1'b1 : wr_q;
        rd_d     = pop ? rd_q + 1'b1 : rd_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        body_d   = body_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        status_d = status_q;
        fail     = 1'b0;
        if (push) mem_d[wr_q] = {i_cmd_addr, i_cmd_op, i_cmd_payload};
        case (state_q)
            IDLE: if (pop) begin
                body_d  = mem_q[rd_q];
                retry_d = '0;
                cnt_d   = '0;
                crc_d   = '0;
                state_d = TXCRC;
            end
            TXCRC: begin
                crc_d = crc_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == 6'd47) begin
                    tx_d    = {body_q, crc_nxt};
                    state_d = SEND;
                end
            end
            SEND: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (i_rx_done) begin
                rx_d     = i_rx_command;
                fail     = i_rx_error;
                status_d = i_rx_error ? 2'b01 : status_q;
                cnt_d    = '0;
                crc_d    = '0;
                state_d  = RXCRC;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                rx_d     = '0;
                fail     = 1'b1;
                status_d = 2'b10;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
            RXCRC: begin
                crc_d = crc_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == 6'd47) begin
                    fail     = crc_nxt != rx_q[7:0];
                    status_d = fail ? 2'b11 : 2'b00;
                    state_d  = RESP;
                end
            end
            RESP: state_d = i_rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        // Failures override the normal next state: resend the unchanged frame or give up
        if (fail) begin
            retry_d = retry_q < RW'(MAX_RETRY) ? retry_q + 1'b1 : retry_q;
            state_d = retry_q < RW'(MAX_RETRY) ? SEND : RESP;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mem_q    <= '{default: '0};
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            body_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            crc_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            retry_q  <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            level_q  <= level_d;
            body_q   <= body_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            retry_q  <= retry_d;
            status_q <= status_d;
        end
    end
endmodule

// File: tb/tb_onewire_cmd_ctrl.sv
// tb_onewire_cmd_ctrl: directed checks of framing, CRC, retries, timeout, FIFO flow control and reset abort.
module tb_onewire_cmd_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic        i_cmd_valid = 1'b0, i_rx_error = 1'b0, i_rx_done = 1'b0, i_rsp_ready = 1'b0;
    logic [7:0]  i_cmd_addr = '0, i_cmd_op = '0;
    logic [31:0] i_cmd_payload = '0;
    logic [55:0] i_rx_command = '0;
    logic        o_cmd_ready, o_tx_start, o_rsp_valid, o_busy;
    logic [55:0] o_tx_data, o_rsp_data;
    logic [1:0]  o_rsp_status;
    logic [2:0]  o_fifo_level;
    int checks = 0, failures = 0, cyc = 0, n_start = 0, n_rsp = 0, max_level = 0;

    onewire_cmd_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(20), .MAX_RETRY(2)) dut (
        .clk(clk), .reset(reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_addr(i_cmd_addr), .i_cmd_op(i_cmd_op), .i_cmd_payload(i_cmd_payload),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_rx_command(i_rx_command),
        .i_rx_error(i_rx_error), .i_rx_done(i_rx_done), .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data), .o_rsp_status(o_rsp_status),
        .o_busy(o_busy), .o_fifo_level(o_fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (o_tx_start) n_start <= n_start + 1;
        if (o_rsp_valid && i_rsp_ready) n_rsp <= n_rsp + 1;
        if (int'(o_fifo_level) > max_level) max_level <= int'(o_fifo_level);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-wise Maxim CRC-8 over bytes [15:8] first through [55:48] last
    function automatic logic [7:0] crc_ref(input logic [47:0] body);
        logic [7:0] c, b;
        c = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b = body[8*i +: 8];
            for (int j = 0; j < 8; j++) begin
                c = (c[0] ^ b[0]) ? ((c >> 1) ^ 8'h8C) : (c >> 1);
                b = b >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [55:0] frame(input logic [47:0] body);
        return {body, crc_ref(body)};
    endfunction

    task automatic push_req(input logic [47:0] body, output int stall);
        {i_cmd_addr, i_cmd_op, i_cmd_payload} = body;
        i_cmd_valid = 1'b1;
        stall = 0;
        while (!o_cmd_ready && stall < 500) begin
            @(negedge clk);
            stall++;
        end
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag, output int at);
        int i = 0;
        while (!o_tx_start && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (!o_tx_start) chk({tag, "_start_timeout"}, 64'd0, 64'd1);
        at = cyc;
    endtask

    task automatic respond(input logic [55:0] f, input logic err);
        @(negedge clk);
        i_rx_command = f;
        i_rx_error = err;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        i_rx_error = 1'b0;
    endtask

    task automatic finish_rsp(input string tag, input logic [1:0] st, input logic [55:0] d, input int hold);
        int i = 0, unstable = 0;
        logic [55:0] d0;
        logic [1:0] s0;
        while (!o_rsp_valid && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd1);
        d0 = o_rsp_data;
        s0 = o_rsp_status;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!o_rsp_valid || o_rsp_data !== d0 || o_rsp_status !== s0) unstable++;
        end
        if (hold > 0) chk({tag, "_rsp_stable"}, 64'(unstable), 64'd0);
        chk({tag, "_status"}, 64'(o_rsp_status), 64'(st));
        chk({tag, "_data"}, 64'(o_rsp_data), 64'(d));
        i_rsp_ready = 1'b1;
        @(negedge clk);
        i_rsp_ready = 1'b0;
        chk({tag, "_rsp_released"}, 64'(o_rsp_valid), 64'd0);
    endtask

    logic [47:0] q_body [5];
    logic [55:0] f;
    int t0, t1, t2, s, stalls, n0, r0;

    initial begin
        q_body[0] = 48'h01_10_00000001;
        q_body[1] = 48'h02_20_12345678;
        q_body[2] = 48'h03_30_9ABCDEF0;
        q_body[3] = 48'hF4_40_55AA55AA;
        q_body[4] = 48'h85_50_FFFFFFFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 64'(o_cmd_ready), 64'd1);
        chk("rst_level", 64'(o_fifo_level), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_outs", {o_tx_data, 5'd0, o_tx_start, o_rsp_valid, o_rsp_status[0]}, 64'd0);
        chk("rst_rsp", {o_rsp_data, 6'd0, o_rsp_status}, 64'd0);

        // All-zero request: frame and CRC both zero, start 49 edges after the push edge
        push_req(48'h0, s);
        t0 = cyc;
        wait_start("zero", t1);
        chk("zero_latency", 64'(t1 - t0), 64'd49);
        chk("zero_tx", 64'(o_tx_data), 64'd0);
        respond(56'h0, 1'b0);
        finish_rsp("zero", 2'b00, 56'h0, 0);

        // Five back-to-back pushes with no response: one is popped, four fill the FIFO
        stalls = 0;
        for (int k = 0; k < 5; k++) begin
            push_req(q_body[k], s);
            stalls += s;
        end
        chk("q_nostall", 64'(stalls), 64'd0);
        chk("q_full_ready", 64'(o_cmd_ready), 64'd0);
        chk("q_full_level", 64'(o_fifo_level), 64'd4);
        for (int k = 0; k < 5; k++) begin
            wait_start("q", t1);
            chk($sformatf("q%0d_tx", k), 64'(o_tx_data), 64'(frame(q_body[k])));
            respond(frame(q_body[k]), 1'b0);
            finish_rsp($sformatf("q%0d", k), 2'b00, frame(q_body[k]), 0);
        end
        chk("q_max_level", 64'(max_level), 64'd4);

        // No reply at all: three sends 21 cycles apart, then TIMEOUT with zero data
        n0 = n_start;
        push_req(48'h11_22_33445566, s);
        wait_start("to1", t0);
        chk("to_tx", 64'(o_tx_data), 64'(frame(48'h11_22_33445566)));
        @(negedge clk);
        wait_start("to2", t1);
        @(negedge clk);
        wait_start("to3", t2);
        chk("to_gap1", 64'(t1 - t0), 64'd21);
        chk("to_gap2", 64'(t2 - t1), 64'd21);
        finish_rsp("to", 2'b10, 56'h0, 0);
        chk("to_starts", 64'(n_start - n0), 64'd3);

        // RX error then a good frame; a stray rx_done during TXCRC must be ignored
        n0 = n_start;
        push_req(48'hA5_3C_DEADBEEF, s);
        repeat (5) @(negedge clk);
        respond(56'hFF, 1'b1);
        wait_start("rxe1", t0);
        chk("rxe_tx1", 64'(o_tx_data), 64'(frame(48'hA5_3C_DEADBEEF)));
        respond(56'h0, 1'b1);
        wait_start("rxe2", t1);
        chk("rxe_tx2", 64'(o_tx_data), 64'(frame(48'hA5_3C_DEADBEEF)));
        f = frame(48'h12_34_56789ABC);
        respond(f, 1'b0);
        finish_rsp("rxe", 2'b00, f, 0);
        chk("rxe_starts", 64'(n_start - n0), 64'd2);

        // CRC off by one bit on every attempt: CRC_BAD after three, response held 10 cycles
        n0 = n_start;
        push_req(48'h28_44_0BADF00D, s);
        f = frame(48'h9C_01_00C0FFEE) ^ 56'h1;
        for (int k = 0; k < 3; k++) begin
            wait_start("crc", t0);
            respond(f, 1'b0);
        end
        finish_rsp("crc", 2'b11, f, 10);
        chk("crc_starts", 64'(n_start - n0), 64'd3);

        // Reset while waiting with two entries queued aborts everything
        push_req(q_body[0], s);
        push_req(q_body[1], s);
        push_req(q_body[2], s);
        wait_start("rst", t0);
        @(negedge clk);
        chk("rst_pre_level", 64'(o_fifo_level), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_abort_level", 64'(o_fifo_level), 64'd0);
        chk("rst_abort_busy", 64'(o_busy), 64'd0);
        chk("rst_abort_tx", 64'(o_tx_data), 64'd0);
        n0 = n_start;
        r0 = n_rsp;
        i_rsp_ready = 1'b1;
        repeat (60) @(negedge clk);
        i_rsp_ready = 1'b0;
        chk("rst_no_start", 64'(n_start - n0), 64'd0);
        chk("rst_no_rsp", 64'(n_rsp - r0), 64'd0);
        push_req(48'h7E_01_CAFEBABE, s);
        t0 = cyc;
        wait_start("post", t1);
        chk("post_latency", 64'(t1 - t0), 64'd49);
        chk("post_tx", 64'(o_tx_data), 64'(frame(48'h7E_01_CAFEBABE)));
        respond(frame(48'h7E_01_CAFEBABE), 1'b0);
        finish_rsp("post", 2'b00, frame(48'h7E_01_CAFEBABE), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/onewire_cmd_ctrl.md
Name: onewire_cmd_ctrl

Overview:
- Command sequencer directly upstream of the onewire master. Drives its 56-bit transmit word and start strobe, and consumes its receive word and error flag.
- Queues host requests in a small FIFO and builds each 56-bit frame with a CRC-8 trailer.
- Launches each transaction, waits for the master's response with a timeout, verifies the response CRC, and retries on failure.
- Returns one response record per request to the host through a valid/ready interface.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; must be a power of two, 2 or greater.
- TIMEOUT_CYCLES, 100000, clk cycles spent in WAIT before a transaction is declared timed out.
- MAX_RETRY, 2, re-sends allowed after the first attempt, so total attempts = MAX_RETRY+1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  host request valid.
- o_cmd_ready  out  1  FIFO not full.
- i_cmd_addr  in  8  device address, placed in frame [55:48].
- i_cmd_op  in  8  opcode, placed in frame [47:40].
- i_cmd_payload  in  32  payload, placed in frame [39:8].
- o_tx_data  out  56  frame to the master; [7:0] holds the CRC.
- o_tx_start  out  1  one-cycle start pulse to the master.
- i_rx_command  in  56  response frame from the master.
- i_rx_error  in  1  master receive error, sampled with i_rx_done.
- i_rx_done  in  1  one-cycle strobe from the master: response complete.
- o_rsp_valid  out  1  response record valid.
- i_rsp_ready  in  1  host accepts the response.
- o_rsp_data  out  56  received frame (last attempt).
- o_rsp_status  out  2  00 OK, 01 RX_ERR, 10 TIMEOUT, 11 CRC_BAD.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high):
  - FSM to IDLE; FIFO flushed (level 0).
  - All outputs 0, except o_cmd_ready = 1 in the first cycle after reset.
  - Reset in any state aborts the transaction: no tx_start pulse and no response is issued.
- FIFO:
  - Push when i_cmd_valid && o_cmd_ready; o_cmd_ready = (level != FIFO_DEPTH).
  - Pop only in IDLE when level > 0.
  - Push and pop in the same cycle leave the level unchanged, including when full.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- CRC-8:
  - Maxim form, reflected polynomial 0x8C, init 0x00, no final XOR.
  - Computed serially, one bit per cycle, over frame bits [8] up to [55] in ascending index order (48 cycles).
  - This equals the standard byte-wise Maxim CRC over bytes [15:8] first through [55:48] last.
- FSM states and transitions:
  - IDLE: on level > 0, pop the entry, latch the 48-bit body, clear the retry count, go to TXCRC.
  - TXCRC: 48 cycles; then write o_tx_data = {body, crc}, go to SEND.
  - SEND: o_tx_start = 1 for exactly this cycle; clear the timeout counter, go to WAIT.
  - WAIT:
    - On i_rx_done, latch i_rx_command and i_rx_error. Error set → fail with RX_ERR; otherwise go to RXCRC.
    - If the counter reaches TIMEOUT_CYCLES-1 without i_rx_done → fail with TIMEOUT.
    - If i_rx_done arrives in the expiry cycle, i_rx_done wins.
  - RXCRC: 48 cycles of CRC over the latched [55:8]. Result equals latched [7:0] → RESP with OK; otherwise fail with CRC_BAD.
  - Fail handling: if retry count < MAX_RETRY, increment it and go to SEND (o_tx_data unchanged, CRC not recomputed). Otherwise go to RESP with the failure status.
  - RESP:
    - o_rsp_valid = 1; o_rsp_data and o_rsp_status are held stable until i_rsp_ready.
    - On TIMEOUT, o_rsp_data = 0.
    - Handshake cycle → IDLE. IDLE may pop the next entry in the following cycle.
- Other rules:
  - o_tx_data holds its value from SEND until the next TXCRC completes.
  - i_rx_done outside WAIT is ignored.
  - Minimum latency from push into an empty FIFO to o_tx_start: 1 (push) + 1 (IDLE) + 48 (TXCRC) = 50 cycles.

Test Plan:
1. Push addr=00, op=00, payload=0 → o_tx_data = 56'h0 (CRC 00); one tx_start pulse 50 cycles after the push. Respond i_rx_done with i_rx_command=0, i_rx_error=0 → status 00, rsp_data 0.
2. Push 5 requests back-to-back with FIFO_DEPTH=4 and no response given → o_cmd_ready drops after the 4th accepted push (or 5th, because IDLE pops one). o_fifo_level never exceeds 4, and all requests are served in order.
3. TIMEOUT_CYCLES=20, MAX_RETRY=2, never assert i_rx_done → exactly 3 tx_start pulses, each separated by the 20-cycle WAIT; then status 10 and rsp_data 0.
4. First attempt: i_rx_done with i_rx_error=1. Second attempt: a valid frame whose [7:0] matches a reference-model CRC → 2 tx_start pulses, final status 00.
5. Respond with a frame whose last byte is the correct CRC XOR 01 on every attempt → 3 attempts, status 11. Hold i_rsp_ready low for 10 cycles → o_rsp_valid and data stay stable throughout.
6. Assert reset in WAIT with 2 entries queued → the next cycle shows level 0, o_busy 0, no response issued. Post-reset pushes are served normally.
